// File: rtl/prog_loader.sv
// UART program loader: receives SYNC/COUNT/(INSTR,DATA)* frames and writes a 16-entry program memory.
// Optional trailing XOR checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_instr,
  output logic [3:0] rd_data,
  output logic       busy,
  output logic       load_done,
  output logic       load_err,
  output logic [4:0] words_loaded
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_INSTR, S_DATA, S_CHECK, S_DONE} state_t;

  // ---------------------------------------------------------------------------
  // RX synchronizer and edge detector
  // ---------------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  // Sync flops reset low so a line already low at reset release can never look
  // like a fresh falling edge; a real high must be seen first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr, shift_en, stop_ok, stop_bad;
  logic          byte_valid, byte_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rx_state <= R_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise paths
    // that skip an assignment infer latches.
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
      R_START: if (cnt == HALF_LAST) rx_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (cnt == BIT_LAST && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP:  if (cnt == BIT_LAST) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (rx_state)
      R_IDLE:  cnt_clr = 1'b1;
      R_START: cnt_clr = (cnt == HALF_LAST);
      R_DATA: begin
        cnt_clr  = (cnt == BIT_LAST);
        shift_en = (cnt == BIT_LAST);
      end
      R_STOP: begin
        cnt_clr  = (cnt == BIT_LAST);
        stop_ok  = (cnt == BIT_LAST) &&  rx_sync;
        stop_bad = (cnt == BIT_LAST) && !rx_sync;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      cnt        <= cnt_clr ? '0 : cnt + CW'(1);
      byte_valid <= stop_ok;
      byte_err   <= stop_bad;
      if (rx_state == R_START) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_next;
  logic [4:0]  count, index, index_inc;
  logic [7:0]  pending;
  logic [11:0] mem [16];
  logic        count_ok, count_we, instr_we, mem_we;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign index_inc = index + 5'd1;
  assign count_ok  = (shreg != 8'd0) && (shreg <= 8'd16);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == S_DONE) begin
      state_next = S_IDLE;
    end else if (byte_err) begin
      state_next = S_IDLE;
    end else if (byte_valid) begin
      case (state)
        S_IDLE:  if (shreg == SYNC_BYTE) state_next = S_COUNT;
        S_COUNT: state_next = count_ok ? S_INSTR : S_IDLE;
        S_INSTR: state_next = S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
        S_DATA:  state_next = (index_inc < count) ? S_INSTR : S_CHECK;
        S_CHECK: state_next = (shreg == csum) ? S_DONE : S_IDLE;
`else
        S_DATA:  state_next = (index_inc < count) ? S_INSTR : S_DONE;
`endif
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_COUNT) || (state == S_INSTR) ||
                (state == S_DATA)  || (state == S_CHECK);
    load_done = (state == S_DONE);
    load_err  = 1'b0;
    count_we  = 1'b0;
    instr_we  = 1'b0;
    mem_we    = 1'b0;
    // Bytes landing during the single S_DONE cycle are dropped so done and err never coincide.
    if (state != S_DONE) begin
      if (byte_err) begin
        load_err = 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_COUNT: begin
            count_we = count_ok;
            load_err = !count_ok;
          end
          S_INSTR: instr_we = 1'b1;
          S_DATA:  mem_we   = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          S_CHECK: load_err = (shreg != csum);
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count        <= '0;
      index        <= '0;
      pending      <= '0;
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      if (count_we) begin
        count <= shreg[4:0];
        index <= '0;
      end
      if (instr_we) pending <= shreg;
      if (mem_we)   index   <= index_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (count_we)               csum <= shreg;
      else if (instr_we || mem_we) csum <= csum ^ shreg;
`endif
      if (load_done)     words_loaded <= count;
      else if (load_err) words_loaded <= '0;
    end
  end

  // NOTE: the memory is flop-based with an async reset because every entry
  // must read back as halt the moment RST asserts; a RAM macro cannot do that.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= {8'h01, 4'h0};
    end else if (mem_we) begin
      mem[index[3:0]] <= {pending, shreg[3:0]};
    end
  end

  // Reads are straight off the flops, so a same-cycle write shows up one cycle later.
  assign rd_instr = mem[rd_addr][11:4];
  assign rd_data  = mem[rd_addr][3:0];

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames are sent over RX, expected pulses are queued
// on send and matched against a pulse monitor; memory is compared against a bench model.
module tb_prog_loader;

  localparam int         CPB  = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_instr;
  logic [3:0] rd_data;
  logic       busy, load_done, load_err;
  logic [4:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] kind;   // 2'b10 done, 2'b01 err
    logic [4:0] words;
    logic       busy;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] byte_q[$];
  logic [11:0] model [16];

  logic       cap_pending = 1'b0;
  logic [1:0] cap_kind = 2'b00;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .CLK(clk), .RST(rst), .RX(rx),
    .rd_addr(rd_addr), .rd_instr(rd_instr), .rd_data(rd_data),
    .busy(busy), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  // Pulse monitor: records each done/err pulse with words_loaded and busy one cycle later.
  always @(negedge clk) begin
    if (cap_pending) begin
      obs_q.push_back('{kind: cap_kind, words: words_loaded, busy: busy});
      cap_pending = 1'b0;
    end
    if (load_done || load_err) begin
      cap_kind    = {load_done, load_err};
      cap_pending = 1'b1;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = {8'h01, 4'h0};
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB / 4) @(negedge clk);
  endtask

  task automatic send_queue();
    while (byte_q.size() > 0) send_byte(byte_q.pop_front(), 1'b1);
  endtask

  // Queue a random valid frame of n entries, update the model and expect a done pulse.
  task automatic queue_frame(input int n);
    logic [7:0] ins, dat, chk;
    byte_q.push_back(SYNC);
    byte_q.push_back(8'(n));
    chk = 8'(n);
    for (int i = 0; i < n; i++) begin
      ins = 8'($urandom);
      dat = 8'($urandom);
      byte_q.push_back(ins);
      byte_q.push_back(dat);
      chk = chk ^ ins ^ dat;
      model[i] = {ins, dat[3:0]};
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    byte_q.push_back(chk);
`endif
    exp_q.push_back('{kind: 2'b10, words: 5'(n), busy: 1'b0});
  endtask

  // Scoreboard pop side: match each expected pulse, then confirm nothing extra arrived.
  task automatic drain_scoreboard(input string tag);
    ev_t e, o;
    int  waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (obs_q.size() == 0 && waited < 10 * CPB) begin
        @(negedge clk);
        waited++;
      end
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s timeout: no pulse seen, required kind=%b words=%0d", tag, e.kind, e.words);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL %s event: got kind=%b words=%0d busy=%b, required kind=%b words=%0d busy=%b",
                   tag, o.kind, o.words, o.busy, e.kind, e.words, e.busy);
        end
      end
    end
    repeat (2 * CPB) @(negedge clk);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s spurious: %0d unexpected pulses, required 0", tag, obs_q.size());
      obs_q.delete();
    end
  endtask

  // Scoreboard memory side: every address read combinationally against the model.
  task automatic scoreboard_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      vectors++;
      if ({rd_instr, rd_data} !== model[a]) begin
        miscompares++;
        $display("FAIL %s mem[%0d]: got %h/%h, required %h/%h",
                 tag, a, rd_instr, rd_data, model[a][11:4], model[a][3:0]);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, load_done, load_err, words_loaded} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b words=%0d, required all 0",
               busy, load_done, load_err, words_loaded);
    end
    scoreboard_mem("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_load();
    logic [7:0] f [6] = '{8'hA5, 8'h02, 8'h08, 8'h03, 8'h10, 8'h00};
    for (int i = 0; i < 6; i++) byte_q.push_back(f[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    byte_q.push_back(8'h02 ^ 8'h08 ^ 8'h03 ^ 8'h10 ^ 8'h00);
`endif
    model[0] = {8'h08, 4'h3};
    model[1] = {8'h10, 4'h0};
    exp_q.push_back('{kind: 2'b10, words: 5'd2, busy: 1'b0});
    send_queue();
    drain_scoreboard("basic");
    scoreboard_mem("basic");
  endtask

  task automatic test_bad_count();
    byte_q.push_back(SYNC); byte_q.push_back(8'h00);
    exp_q.push_back('{kind: 2'b01, words: 5'd0, busy: 1'b0});
    send_queue();
    drain_scoreboard("count_zero");
    byte_q.push_back(SYNC); byte_q.push_back(8'h11);
    exp_q.push_back('{kind: 2'b01, words: 5'd0, busy: 1'b0});
    send_queue();
    drain_scoreboard("count_17");
    scoreboard_mem("bad_count");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q.push_back(SYNC); byte_q.push_back(8'h01);
    byte_q.push_back(8'h20); byte_q.push_back(8'h05);
    byte_q.push_back(8'hFF);
    model[0] = {8'h20, 4'h5};
    exp_q.push_back('{kind: 2'b01, words: 5'd0, busy: 1'b0});
    send_queue();
    drain_scoreboard("checksum");
    scoreboard_mem("checksum");
  endtask
`endif

  task automatic test_stop_err();
    send_byte(SYNC, 1'b1);
    exp_q.push_back('{kind: 2'b01, words: 5'd0, busy: 1'b0});
    send_byte(8'h02, 1'b0);
    drain_scoreboard("stop_err");
    scoreboard_mem("stop_err");
    queue_frame(3);
    send_queue();
    drain_scoreboard("after_stop_err");
    scoreboard_mem("after_stop_err");
  endtask

  task automatic test_back_to_back();
    send_byte(8'h3C, 1'b1);            // stray byte while idle
    @(negedge clk); rx = 1'b0;         // glitch shorter than half a bit
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    drain_scoreboard("idle_noise");
    queue_frame(5);
    queue_frame(4);
    send_queue();
    drain_scoreboard("back_to_back");
    scoreboard_mem("back_to_back");
  endtask

  task automatic test_full16();
    queue_frame(16);
    send_queue();
    drain_scoreboard("full16");
    scoreboard_mem("full16");
  endtask

  task automatic test_reset_midframe();
    queue_frame(16);
    void'(exp_q.pop_back());           // frame never completes
    for (int i = 0; i < 9; i++) send_byte(byte_q.pop_front(), 1'b1);
    byte_q.delete();
    @(negedge clk); rx = 1'b0;         // start bit of entry 3 DATA byte
    repeat (4 * CPB) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if ({busy, load_done, load_err, words_loaded} !== 8'b0) begin
      miscompares++;
      $display("FAIL midframe_reset_outputs: got busy=%b done=%b err=%b words=%0d, required all 0",
               busy, load_done, load_err, words_loaded);
    end
    scoreboard_mem("midframe_reset");
    rx = 1'b0;                         // line still low when reset releases
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_busy: got %b, required 0", busy);
    end
    drain_scoreboard("post_reset_idle");
    queue_frame(2);
    send_queue();
    drain_scoreboard("post_reset_load");
    scoreboard_mem("post_reset_load");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_count();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_stop_err();
    test_back_to_back();
    test_full16();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
